mac_dot_accum: RTL

Parametrised multi-lane signed multiply-accumulate engine. It accepts a stream of beats of `LANES` operand pairs and sums the lane products into a wide accumulator. At the end of each vector (`in_last`) it emits one dot-product result. It replaces the single-lane, free-running MAC accumulator in the datapath: it adds lane parallelism, vector framing, optional saturation, overflow reporting and valid/ready flow control on both sides.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_lane_tree.sv | 22 ++
 rtl/mac_dot_accum.sv | 102 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared lane-sum width and saturating accumulate helper
package mac_pkg;
  localparam int WIDE_W = 128;
  typedef logic [WIDE_W-1:0] wide_t;
  function automatic int psum_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction
  // s is an (acc_w+1)-bit sum sign-extended to WIDE_W; only the low acc_w bits of the result matter
  function automatic wide_t sat_add(input wide_t s, input int acc_w, input logic sat, output logic ovf);
    wide_t mx;
    wide_t top;
    mx = (wide_t'(1) << (acc_w - 1)) - wide_t'(1);
    top = s >> (acc_w - 1);
    ovf = top[1] ^ top[0];
    return (ovf && sat) ? (top[1] ? ~mx : mx) : s;
  endfunction
endpackage

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: per-lane signed products summed into one lane-sum
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int PW     = psum_w(DATA_W, LANES)
) (
  input  logic [LANES*DATA_W-1:0] a_i,
  input  logic [LANES*DATA_W-1:0] b_i,
  output logic signed [PW-1:0]    sum_o
);
  logic signed [2*DATA_W-1:0] prod [LANES];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i] = $signed(a_i[i*DATA_W +: DATA_W]) * $signed(b_i[i*DATA_W +: DATA_W]);
  end
  // Sign-extended sum of all lane products; PW is wide enough that it never overflows
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) sum_o = sum_o + PW'(prod[i]);
  end
endmodule

// File: rtl/mac_dot_accum.sv
// mac_dot_accum: multi-lane signed dot-product accumulator with framing and flow control
module mac_dot_accum
  import mac_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        out_beats
);
  localparam int PW = psum_w(DATA_W, LANES);
  logic signed [PW-1:0] p_sum_d, p_sum_q;
  logic                 p_valid_q, p_last_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 first_q, ovf_acc_q, ovf;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_ovf_q;
  logic [ACC_W-1:0]     out_data_q;
  logic [CNT_W-1:0]     out_beats_q;
  logic [ACC_W:0]       sum_w;
  wide_t                sat_w;
  logic                 unused_hi;
  logic                 hold, accept, step;
  mac_lane_tree #(.LANES(LANES), .DATA_W(DATA_W), .PW(PW)) u_tree (
    .a_i  (in_a),
    .b_i  (in_b),
    .sum_o(p_sum_d)
  );
  assign hold      = out_valid_q & ~out_ready;
  assign in_ready  = ~hold;
  assign accept    = in_valid & ~hold;
  assign step      = p_valid_q & ~hold;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_beats = out_beats_q;
  assign unused_hi = ^sat_w[WIDE_W-1:ACC_W];
  // Next accumulator value at ACC_W+1 bits, clamped or wrapped, plus saturating beat count
  always_comb begin
    sum_w = (first_q ? '0 : {acc_q[ACC_W-1], acc_q}) + (ACC_W+1)'(p_sum_q);
    sat_w = sat_add(wide_t'($signed(sum_w)), ACC_W, SATURATE, ovf);
    acc_d = sat_w[ACC_W-1:0];
    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
  end
  // Stage 1: capture the lane-sum of each accepted beat, frozen while the output is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_sum_q   <= '0;
    end else if (!hold) begin
      p_valid_q <= accept;
      if (accept) begin
        p_sum_q  <= p_sum_d;
        p_last_q <= in_last;
      end
    end
  end
  // Stage 2: running sum, sticky overflow and beat count, restarted after each last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (step) begin
      acc_q     <= acc_d;
      first_q   <= p_last_q;
      ovf_acc_q <= p_last_q ? 1'b0 : (ovf_acc_q | ovf);
      cnt_q     <= p_last_q ? '0 : cnt_d;
    end
  end
  // Result register: loads on a last beat, otherwise drops valid once consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (!hold) begin
      out_valid_q <= p_valid_q & p_last_q;
      if (p_valid_q & p_last_q) begin
        out_data_q  <= acc_d;
        out_ovf_q   <= ovf_acc_q | ovf;
        out_beats_q <= cnt_d;
      end
    end
  end
endmodule
